// File: rtl/systolic_skew_feeder.sv
// Tile buffer and diagonal-skew replay for the 8x8 systolic array.
// Captures DIM beats, then drives CLEAR, skewed STREAM and FLUSH, and pulses done.
module systolic_skew_feeder #(
    parameter int                      ACT_WIDTH    = 8,
    parameter int                      WGT_WIDTH    = 8,
    parameter int                      DIM          = 8,
    parameter int                      OP_SIG_WIDTH = 3,
    parameter logic [OP_SIG_WIDTH-1:0] OP_IDLE      = 3'd0,
    parameter logic [OP_SIG_WIDTH-1:0] OP_CLEAR     = 3'd1,
    parameter logic [OP_SIG_WIDTH-1:0] OP_RUN       = 3'd2,
    parameter int                      FLUSH_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DIM*ACT_WIDTH-1:0]    in_a,
    input  logic [DIM*WGT_WIDTH-1:0]    in_w,
    output logic [DIM*ACT_WIDTH-1:0]    a_out,
    output logic [DIM*WGT_WIDTH-1:0]    w_out,
    output logic [OP_SIG_WIDTH-1:0]     op_out,
    output logic                        busy,
    output logic                        done
);

    localparam int BW          = $clog2(DIM) + 1;
    localparam int IW          = $clog2(DIM);
    localparam int STREAM_LAST = 2 * DIM - 2;
    localparam int MAXV        = (2 * DIM - 1 > FLUSH_CYCLES) ? 2 * DIM - 1 : FLUSH_CYCLES;
    localparam int SW          = (MAXV > 1) ? $clog2(MAXV) : 1;
    localparam int FLUSH_LAST  = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;

    // The done cycle is the first LOAD cycle, so a new tile can start there.
    typedef enum logic [1:0] {
        S_LOAD,
        S_CLEAR,
        S_STREAM,
        S_FLUSH
    } state_t;

    state_t                       state_q, state_d;
    logic [BW-1:0]                beat_q, beat_d;
    logic [SW-1:0]                step_q, step_d;
    logic [DIM*ACT_WIDTH-1:0]     a_q, a_d;
    logic [DIM*WGT_WIDTH-1:0]     w_q, w_d;
    logic [OP_SIG_WIDTH-1:0]      op_q, op_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         accept;
    logic                         leaving;

    logic [DIM*ACT_WIDTH-1:0]     a_buf_q [DIM];
    logic [DIM*WGT_WIDTH-1:0]     w_buf_q [DIM];

    assign in_ready = (state_q == S_LOAD);
    assign accept   = in_valid && in_ready;
    assign leaving  = (state_q != S_LOAD) && (state_d == S_LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOAD;
            beat_q  <= '0;
            step_q  <= '0;
            a_q     <= '0;
            w_q     <= '0;
            op_q    <= OP_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            step_q  <= step_d;
            a_q     <= a_d;
            w_q     <= w_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_buf_q[beat_q[IW-1:0]] <= in_a;
            w_buf_q[beat_q[IW-1:0]] <= in_w;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        step_d  = step_q;
        unique case (state_q)
            S_LOAD: begin
                if (accept) begin
                    if (beat_q == BW'(DIM - 1)) begin
                        state_d = S_CLEAR;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
                step_d  = '0;
            end
            S_STREAM: begin
                if (step_q == SW'(STREAM_LAST)) begin
                    state_d = (FLUSH_CYCLES > 0) ? S_FLUSH : S_LOAD;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (step_q == SW'(FLUSH_LAST)) begin
                    state_d = S_LOAD;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            default: begin
                state_d = S_LOAD;
                step_d  = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so they line up with it.
    always_comb begin
        a_d    = '0;
        w_d    = '0;
        op_d   = OP_IDLE;
        busy_d = busy_q;
        done_d = leaving;
        if (accept) begin
            busy_d = 1'b1;
        end
        if (leaving) begin
            busy_d = 1'b0;
        end
        unique case (state_d)
            S_CLEAR:  op_d = OP_CLEAR;
            S_STREAM: op_d = OP_RUN;
            S_FLUSH:  op_d = OP_RUN;
            default:  op_d = OP_IDLE;
        endcase
        if (state_d == S_STREAM) begin
            for (int i = 0; i < DIM; i++) begin
                if (int'(step_d) >= i && int'(step_d) < i + DIM) begin
                    a_d[i*ACT_WIDTH +: ACT_WIDTH] =
                        a_buf_q[IW'(int'(step_d) - i)][i*ACT_WIDTH +: ACT_WIDTH];
                    w_d[i*WGT_WIDTH +: WGT_WIDTH] =
                        w_buf_q[IW'(int'(step_d) - i)][i*WGT_WIDTH +: WGT_WIDTH];
                end
            end
        end
    end

    assign a_out  = a_q;
    assign w_out  = w_q;
    assign op_out = op_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: table spot checks plus
// cycle-by-cycle tile sweeps, gapped loads, back-to-back tiles and reset abort.
module tb_systolic_skew_feeder;

    localparam int DIM = 8;
    localparam logic [2:0] OP_IDLE  = 3'd0;
    localparam logic [2:0] OP_CLEAR = 3'd1;
    localparam logic [2:0] OP_RUN   = 3'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_a = '0;
    logic [63:0] in_w = '0;
    logic [63:0] a_out;
    logic [63:0] w_out;
    logic [2:0]  op_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          off;
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] w;
        logic        busy;
        logic        done;
        logic        rdy;
    } vec_t;

    vec_t tbl [8];

    systolic_skew_feeder dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_w     (in_w),
        .a_out    (a_out),
        .w_out    (w_out),
        .op_out   (op_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [133:0] pack(logic [2:0] op, logic [63:0] a,
                                          logic [63:0] w, logic b, logic d,
                                          logic r);
        return {op, a, w, b, d, r};
    endfunction

    function automatic logic [133:0] outs();
        return {op_out, a_out, w_out, busy, done, in_ready};
    endfunction

    task automatic check(string name, logic [133:0] act, logic [133:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] beat_a(int k, int aoff);
        logic [63:0] r;
        for (int i = 0; i < DIM; i++) r[i*8 +: 8] = 8'(aoff + 8 * k + i);
        return r;
    endfunction

    function automatic logic [63:0] beat_w(int k, int woff);
        logic [63:0] r;
        for (int j = 0; j < DIM; j++) r[j*8 +: 8] = 8'(woff + k);
        return r;
    endfunction

    // Expected outputs at cycle E+off for a tile with A[k][i]=aoff+8k+i, W[k][j]=woff+k
    function automatic logic [133:0] model(int off, int aoff, int woff);
        logic [2:0]  op = OP_IDLE;
        logic [63:0] a = '0;
        logic [63:0] w = '0;
        logic        b = 1'b0;
        logic        d = 1'b0;
        logic        r = 1'b1;
        if (off == 1) begin
            op = OP_CLEAR; b = 1'b1; r = 1'b0;
        end else if (off >= 2 && off <= 16) begin
            op = OP_RUN; b = 1'b1; r = 1'b0;
            for (int i = 0; i < DIM; i++) begin
                int k;
                k = off - 2 - i;
                if (k >= 0 && k < DIM) begin
                    a[i*8 +: 8] = 8'(aoff + 8 * k + i);
                    w[i*8 +: 8] = 8'(woff + k);
                end
            end
        end else if (off >= 17 && off <= 24) begin
            op = OP_RUN; b = 1'b1; r = 1'b0;
        end else if (off == 25) begin
            d = 1'b1;
        end
        return pack(op, a, w, b, d, r);
    endfunction

    task automatic load_tile(input int aoff, input int woff, input bit gap,
                             input int kstart);
        int k = kstart;
        int budget = 200;
        bit phase = 1'b0;
        bit acc;
        while (k < DIM && budget > 0) begin
            budget--;
            if (gap && phase) begin
                in_valid = 1'b0;
                in_a = '1;
                in_w = '1;
            end else begin
                in_valid = 1'b1;
                in_a = beat_a(k, aoff);
                in_w = beat_w(k, woff);
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                if (k == 0 && kstart == 0)
                    check("busy after first beat", 134'(busy), 134'(1));
                k++;
            end
            phase = ~phase;
        end
        in_valid = 1'b0;
        check("beats accepted", 134'(k), 134'(DIM));
    endtask

    task automatic check_tile(input int aoff, input int woff, input bit hold,
                              input int naoff, input int nwoff, input bit use_tbl);
        if (hold) begin
            in_valid = 1'b1;
            in_a = beat_a(0, naoff);
            in_w = beat_w(0, nwoff);
        end
        for (int off = 1; off <= 25; off++) begin
            check($sformatf("tile%0h off=%0d", aoff, off), outs(), model(off, aoff, woff));
            if (use_tbl) begin
                foreach (tbl[n]) begin
                    if (tbl[n].off == off)
                        check($sformatf("tbl off=%0d", off), outs(),
                              pack(tbl[n].op, tbl[n].a, tbl[n].w,
                                   tbl[n].busy, tbl[n].done, tbl[n].rdy));
                end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int dn;
        tbl[0] = '{1,  OP_CLEAR, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{2,  OP_RUN, 64'h1, 64'h10, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{3,  OP_RUN, 64'h0209, 64'h1011, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{9,  OP_RUN, 64'h080F161D242B3239, 64'h1011121314151617, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{16, OP_RUN, 64'h4000000000000000, 64'h1700000000000000, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{17, OP_RUN, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{24, OP_RUN, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{25, OP_IDLE, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1};

        reset = 1'b1;
        repeat (3) tick();
        check("in reset", outs(), pack(OP_IDLE, '0, '0, 1'b0, 1'b0, 1'b1));
        reset = 1'b0;
        check("after reset", outs(), pack(OP_IDLE, '0, '0, 1'b0, 1'b0, 1'b1));
        tick();
        check("idle", outs(), pack(OP_IDLE, '0, '0, 1'b0, 1'b0, 1'b1));

        load_tile(1, 8'h10, 1'b0, 0);
        check_tile(1, 8'h10, 1'b0, 0, 0, 1'b1);
        check("post done idle", outs(), pack(OP_IDLE, '0, '0, 1'b0, 1'b0, 1'b1));

        load_tile(1, 8'h10, 1'b1, 0);
        check_tile(1, 8'h10, 1'b0, 0, 0, 1'b0);

        load_tile(1, 8'h10, 1'b0, 0);
        check_tile(1, 8'h10, 1'b1, 8'h80, 8'h40, 1'b0);
        check("b2b beat0 busy", 134'({busy, done}), 134'(2'b10));
        load_tile(8'h80, 8'h40, 1'b0, 1);
        check_tile(8'h80, 8'h40, 1'b0, 0, 0, 1'b0);

        load_tile(8'h80, 8'h40, 1'b0, 0);
        repeat (4) tick();
        check("mid stream op", 134'(op_out), 134'(OP_RUN));
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("abort reset c=%0d", c), outs(),
                  pack(OP_IDLE, '0, '0, 1'b0, 1'b0, 1'b1));
        end
        reset = 1'b0;
        check("abort released", outs(), pack(OP_IDLE, '0, '0, 1'b0, 1'b0, 1'b1));
        dn = 0;
        repeat (30) begin
            tick();
            if (done) dn++;
        end
        check("no done after abort", 134'(dn), 134'(0));

        load_tile(1, 8'h10, 1'b0, 0);
        check_tile(1, 8'h10, 1'b0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
